tff_count_ctrl: RTL and testbench

TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

---
 rtl/tff_count_ctrl.sv | 97 +++++++++
 tb/tb_tff_count_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_count_ctrl.sv
// Start/stop controller that drives a T-flip-flop register as an up-counter
// from 0 to a latched terminal count, then pulses done for one cycle.
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] inc_mask;
  logic             load;

  // A bit toggles on increment when every lower bit is already 1.
  assign inc_mask[0] = 1'b1;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_inc
      assign inc_mask[gi] = &q[gi-1:0];
    end
  endgenerate

  always_comb begin
    state_next = state;
    t          = '0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (limit == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // stop takes priority over reaching the terminal count
        if (stop) begin
          state_next = IDLE;
        end else if (q == lim_r) begin
          state_next = DONE;
        end else begin
          t = inc_mask;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_r <= '0;
    end else if (load) begin
      lim_r <= limit;
    end
  end

  // Toggle register: cleared when a run is accepted, otherwise q ^ t.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl (WIDTH=4): fixed vector table, directed corner
// sequences and random traffic checked against a counting reference model.
module tb_tff_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] t;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: count value, latched limit, and run / done flags.
  int m_q    = 0;
  int m_lim  = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .limit (limit),
    .t     (t),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       p;
    logic [3:0] l;
    logic [3:0] et;
    logic [3:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q = 0; m_lim = 0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  // One clock cycle: t checked before the edge, registered outputs after it.
  task automatic cycle(input logic s, input logic p, input logic [3:0] l);
    int et;
    start = s; stop = p; limit = l;
    #2;
    et = (m_busy && !p && m_q != m_lim) ? ((m_q ^ (m_q + 1)) & 15) : 0;
    chk("t", int'(t), et);
    @(posedge clk);
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (p) m_busy = 1'b0;
      else if (m_q == m_lim) begin m_busy = 1'b0; m_done = 1'b1; end
      else m_q = m_q + 1;
    end else if (s) begin
      m_q = 0;
      m_lim = int'(l);
      if (l == 4'd0) m_done = 1'b1;
      else m_busy = 1'b1;
    end
    #1;
    $display("cyc start=%0b stop=%0b limit=%0d -> q=%0d t=%0d busy=%0b done=%0b",
             s, p, l, q, t, busy, done);
    chk("q", int'(q), m_q);
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    start = 1'b0; stop = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    $display("rst asserted -> q=%0d t=%0d busy=%0b done=%0b", q, t, busy, done);
    chk("rst_q", int'(q), 0);
    chk("rst_t", int'(t), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // limit=3 run, limit=0 run, then stop coinciding with terminal count.
    tbl[0]  = '{1'b1, 1'b0, 4'd3, 4'b0000, 4'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'd3, 4'b0001, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'd9, 4'b0011, 4'd2, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'd3, 4'b0001, 4'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'd3, 4'b0000, 4'd3, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'd3, 4'b0000, 4'd3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'd0, 4'b0000, 4'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'd5, 4'b0000, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'd1, 4'b0000, 4'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'd9, 4'b0001, 4'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'd1, 4'b0000, 4'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 4'd1, 4'b0000, 4'd1, 1'b0, 1'b0};

    rst = 1'b1;
    #12;
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      start = tbl[i].s; stop = tbl[i].p; limit = tbl[i].l;
      #2;
      chk($sformatf("tbl%0d_t", i), int'(t), int'(tbl[i].et));
      @(posedge clk);
      #1;
      $display("vec %0d start=%0b stop=%0b limit=%0d -> q=%0d busy=%0b done=%0b",
               i, tbl[i].s, tbl[i].p, tbl[i].l, q, busy, done);
      chk($sformatf("tbl%0d_q", i), int'(q), int'(tbl[i].eq));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].ed));
    end

    // Reset mid-run at q=2, then a start right after release is honoured.
    do_reset();
    cycle(1'b1, 1'b0, 4'd5);
    cycle(1'b0, 1'b0, 4'd5);
    cycle(1'b0, 1'b0, 4'd5);
    chk("pre_rst_q", int'(q), 2);
    do_reset();
    cycle(1'b1, 1'b0, 4'd7);
    chk("post_rst_busy", int'(busy), 1);
    do_reset();

    // Full-range count: must stop at 15 without wrapping.
    cycle(1'b1, 1'b0, 4'd15);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)));
      if (done) seen = 1'b1;
    end
    chk("full_done_seen", int'(seen), 1);
    chk("full_q", int'(q), 15);
    cycle(1'b0, 1'b0, 4'd0);
    chk("full_idle_q", int'(q), 15);

    // Stop at q=4 with limit=10, then restart from zero.
    cycle(1'b1, 1'b0, 4'd10);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd10);
    cycle(1'b0, 1'b1, 4'd10);
    chk("stop_q", int'(q), 4);
    chk("stop_done", int'(done), 0);
    cycle(1'b0, 1'b0, 4'd10);
    chk("stop_idle_q", int'(q), 4);
    cycle(1'b1, 1'b0, 4'd10);
    chk("restart_q", int'(q), 0);
    chk("restart_busy", int'(busy), 1);
    do_reset();

    // start held high with limit=2; limit moves to 9 while running.
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, m_busy ? 4'd9 : 4'd2);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 4))
                                          : 4'($urandom_range(0, 15)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
